rv32_trap_seq: RTL
==================

Name: rv32_trap_seq

Overview:
Trap and return sequencer: the initiator side of the rv32_csr access interface. It accepts synchronous exceptions, level-sensitive interrupt pending lines and MRET requests from the pipeline. For each, it issues a fixed sequence of CSR accesses (mepc/mcause/mstatus/mtvec, or MRET/mepc), then issues a single-cycle PC redirect plus pipeline flush to fetch. It sits between decode/commit and rv32_csr, one instance per hart.

Parameters:
PITO_HART_ID, 0, hart index; used only in the activation message
MVU_IRQ_IDX, 16, mip bit index of the MVU interrupt
TRAP_ENTRY_OFFSET, 0, byte offset added to the computed trap target

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
exc_valid_i  input  1  synchronous exception from commit
exc_cause_i  input  32  exception code, bit 31 = 0
exc_pc_i  input  32  PC of the faulting instruction
exc_tval_i  input  32  trap value; used only with TRAP_SEQ_TVAL_EN
irq_pending_i  input  32  mip & mie from the CSR file
mstatus_mie_i  input  1  global M-mode interrupt enable
next_pc_i  input  32  PC of the next uncommitted instruction; becomes mepc on an interrupt
mret_i  input  1  MRET committed
csr_addr_o  output  12  CSR address
csr_wdata_o  output  32  CSR write data
csr_op_o  output  3  pito_pkg::csr_op_t
csr_rdata_i  input  32  CSR read data, combinational, same cycle
csr_exception_i  input  1  CSR access fault (csr_exception_o.valid)
busy_o  output  1  sequencer active; pipeline stalls commit
redirect_valid_o  output  1  one-cycle redirect strobe
redirect_pc_o  output  32  redirect target
flush_o  output  1  equals redirect_valid_o
fatal_o  output  1  sticky; CSR fault during a sequence

Behaviour:
- Reset values:
  - csr_op_o = CSR_READ (no-op read) with csr_addr_o = 0 and csr_wdata_o = 0 while idle.
  - busy_o, redirect_valid_o, flush_o, fatal_o = 0; redirect_pc_o = 0; FSM = IDLE.
- Reset mid-sequence aborts the sequence; no redirect is issued.
- Sampling in IDLE uses priority exception > interrupt > mret.
  - An interrupt is taken only if mstatus_mie_i = 1 and (irq_pending_i & mask) != 0.
  - Interrupt priority, highest first: bit 11 MEI, bit 3 MSI, bit 7 MTI, bit MVU_IRQ_IDX.
  - Interrupt cause = {1'b1, 26'b0, idx[4:0]}.
  - Trap PC, cause and kind are latched on the accept edge; busy_o rises the next cycle.
- Trap FSM, one CSR access per cycle, states in order:
  - E_EPC: CSR_READ_WRITE MEPC, wdata = latched PC (exc_pc_i for exceptions, next_pc_i for interrupts).
  - E_CAUSE: CSR_READ_WRITE MCAUSE, wdata = cause.
  - E_TVAL: present only with the macro; see Optional Feature.
  - E_MIE: CSR_CLEAR MSTATUS, wdata = 0x8; latch old_mie = csr_rdata_i[3].
  - E_MPIE: CSR_SET MSTATUS, wdata = 0x80 if old_mie = 1; otherwise CSR_CLEAR, wdata = 0x80.
  - E_VEC: CSR_SET MTVEC, wdata = 0 (read only); latch mtvec.
  - REDIR: redirect_valid_o = 1 for exactly one cycle, then IDLE.
- Return FSM:
  - R_RET: csr_op_o = MRET, wdata = 0.
  - R_EPC: CSR_SET MEPC, wdata = 0 (read only); latch the value.
  - REDIR.
- Target computation, 32-bit wrap-around arithmetic:
  - Trap: base = {mtvec[31:2], 2'b00}.
  - If mtvec[0] = 1 and the trap is an interrupt: target = base + (cause[4:0] << 2).
  - Otherwise: target = base.
  - Add TRAP_ENTRY_OFFSET to the trap target.
  - MRET: target = {mepc[31:1], 1'b0}.
- Latency, accept edge to redirect strobe: trap = 6 cycles (7 with TVAL); MRET = 3 cycles.
- busy_o stays high from the cycle after accept through the REDIR cycle.
- Events while busy:
  - exc_valid_i and mret_i pulses are ignored; commit is stalled, so they cannot legally occur.
  - Interrupts are level-sensitive and are re-sampled in IDLE.
  - IDLE is entered with redirect already issued, so a pending interrupt is accepted the cycle after REDIR.
- CSR fault: csr_exception_i = 1 in any sequencer state → fatal_o = 1 (sticky until rst), FSM → HALT, busy_o held at 1, no redirect.

Optional Feature:
- Macro TRAP_SEQ_TVAL_EN.
- Defined: state E_TVAL is inserted after E_CAUSE. It issues CSR_READ_WRITE MTVAL with wdata = exc_tval_i latched at accept; for interrupts the wdata is 0. Trap latency becomes 7 cycles.
- Undefined: no MTVAL access; exc_tval_i is unused; trap latency is 6 cycles.

Test Plan:
- Exception: exc_valid_i, cause = 2, pc = 0x100, mtvec = 0x40 direct, mstatus_mie_i = 1 → CSR writes mepc = 0x100, mcause = 2; MSTATUS CLEAR 0x8 then SET 0x80; redirect_pc_o = 0x40 at cycle 6, one-cycle strobe.
- Vectored interrupt: irq_pending_i = 0x880, mstatus_mie_i = 1, next_pc_i = 0x204, mtvec = 0x101 → MEI chosen, mcause = 0x8000000B, mepc = 0x204, redirect_pc_o = 0x12C.
- Masked interrupt: irq_pending_i = 0x80 with mstatus_mie_i = 0 → busy_o stays 0, no CSR writes, for 20 cycles.
- MRET: mepc = 0x301 → csr_op_o = MRET, then MEPC read; redirect_pc_o = 0x300 three cycles after accept.
- Priority and busy: exc_valid_i and mret_i in the same cycle with irq_pending_i = 0x8 → exception sequence runs; MSI is taken immediately after REDIR; an mret_i pulse while busy produces no effect.
- Fault and reset: csr_exception_i = 1 during E_CAUSE → fatal_o = 1, no redirect; rst pulse → all outputs return to reset values, and a new exception is accepted normally.

Source files
------------

// File: rtl/rv32_trap_seq.sv
// Trap/return sequencer: walks the CSR accesses for exception/interrupt entry and MRET, then redirects fetch.
// Optional MTVAL write step is compiled in when TRAP_SEQ_TVAL_EN is defined.
module rv32_trap_seq #(
  parameter int          PITO_HART_ID      = 0,
  parameter int          MVU_IRQ_IDX       = 16,
  parameter logic [31:0] TRAP_ENTRY_OFFSET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic [31:0] irq_pending_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] next_pc_i,
  input  logic        mret_i,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [2:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        csr_exception_i,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        fatal_o
);

  localparam logic [2:0] CSR_READ       = 3'd0;
  localparam logic [2:0] CSR_READ_WRITE = 3'd1;
  localparam logic [2:0] CSR_SET        = 3'd2;
  localparam logic [2:0] CSR_CLEAR      = 3'd3;
  localparam logic [2:0] CSR_MRET       = 3'd4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [46:0] IDLE_ACC = {12'h000, CSR_READ, 32'h0000_0000};

  // Interrupt priority list, highest first: MEI, MSI, MTI, MVU.
  localparam logic [4:0] IRQ_PRIO [4] = '{5'd11, 5'd3, 5'd7, 5'(MVU_IRQ_IDX)};

  typedef enum logic [3:0] {
    IDLE, E_EPC, E_CAUSE, E_TVAL, E_MIE, E_MPIE, E_VEC, R_RET, R_EPC, REDIR, HALT
  } state_t;

  state_t      state_r;
  logic [31:0] cause_r;
  logic        irq_r;
  logic        irq_take_s;
  logic [4:0]  irq_idx_s;
  logic [31:0] vec_base_s;
  logic [31:0] trap_target_s;
  logic [31:0] unused_hart;

  assign unused_hart = 32'(PITO_HART_ID);

`ifdef TRAP_SEQ_TVAL_EN
  logic [31:0] tval_r;
`else
  logic [31:0] unused_tval;
  assign unused_tval = exc_tval_i;
`endif

  // Highest-priority enabled interrupt; later (higher-priority) hits overwrite earlier ones.
  always_comb begin
    irq_take_s = 1'b0;
    irq_idx_s  = 5'd0;
    for (int k = 3; k >= 0; k--) begin
      irq_idx_s  = irq_pending_i[IRQ_PRIO[k]] ? IRQ_PRIO[k] : irq_idx_s;
      irq_take_s = irq_take_s | irq_pending_i[IRQ_PRIO[k]];
    end
    irq_take_s = irq_take_s & mstatus_mie_i;
  end

  // Trap target from the mtvec value currently on the read bus (valid in E_VEC).
  always_comb begin
    vec_base_s = {csr_rdata_i[31:2], 2'b00};
    if (irq_r && csr_rdata_i[0]) begin
      trap_target_s = vec_base_s + {25'd0, cause_r[4:0], 2'b00} + TRAP_ENTRY_OFFSET;
    end else begin
      trap_target_s = vec_base_s + TRAP_ENTRY_OFFSET;
    end
  end

  // Sequencer FSM; CSR port and redirect outputs are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      cause_r          <= 32'h0000_0000;
      irq_r            <= 1'b0;
      busy_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
      redirect_pc_o    <= 32'h0000_0000;
      fatal_o          <= 1'b0;
      {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
`ifdef TRAP_SEQ_TVAL_EN
      tval_r           <= 32'h0000_0000;
`endif
    end else if (state_r != IDLE && state_r != HALT && csr_exception_i) begin
      state_r          <= HALT;
      fatal_o          <= 1'b1;
      busy_o           <= 1'b1;
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
      {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
    end else begin
      redirect_valid_o <= 1'b0;
      flush_o          <= 1'b0;
      case (state_r)
        IDLE: begin
          if (exc_valid_i) begin
            cause_r <= exc_cause_i;
            irq_r   <= 1'b0;
`ifdef TRAP_SEQ_TVAL_EN
            tval_r  <= exc_tval_i;
`endif
            busy_o  <= 1'b1;
            state_r <= E_EPC;
            {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MEPC, CSR_READ_WRITE, exc_pc_i};
          end else if (irq_take_s) begin
            cause_r <= {1'b1, 26'd0, irq_idx_s};
            irq_r   <= 1'b1;
`ifdef TRAP_SEQ_TVAL_EN
            tval_r  <= 32'h0000_0000;
`endif
            busy_o  <= 1'b1;
            state_r <= E_EPC;
            {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MEPC, CSR_READ_WRITE, next_pc_i};
          end else if (mret_i) begin
            busy_o  <= 1'b1;
            state_r <= R_RET;
            {csr_addr_o, csr_op_o, csr_wdata_o} <= {12'h000, CSR_MRET, 32'h0000_0000};
          end else begin
            busy_o  <= 1'b0;
            state_r <= IDLE;
            {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
          end
        end
        E_EPC: begin
          state_r <= E_CAUSE;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MCAUSE, CSR_READ_WRITE, cause_r};
        end
        E_CAUSE: begin
`ifdef TRAP_SEQ_TVAL_EN
          state_r <= E_TVAL;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MTVAL, CSR_READ_WRITE, tval_r};
`else
          state_r <= E_MIE;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MSTATUS, CSR_CLEAR, 32'h0000_0008};
`endif
        end
        E_TVAL: begin
          state_r <= E_MIE;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MSTATUS, CSR_CLEAR, 32'h0000_0008};
        end
        E_MIE: begin
          // Old MIE comes back on the read bus while it is being cleared; it becomes MPIE.
          state_r <= E_MPIE;
          if (csr_rdata_i[3]) begin
            {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MSTATUS, CSR_SET, 32'h0000_0080};
          end else begin
            {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MSTATUS, CSR_CLEAR, 32'h0000_0080};
          end
        end
        E_MPIE: begin
          state_r <= E_VEC;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MTVEC, CSR_SET, 32'h0000_0000};
        end
        E_VEC: begin
          state_r          <= REDIR;
          redirect_pc_o    <= trap_target_s;
          redirect_valid_o <= 1'b1;
          flush_o          <= 1'b1;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
        end
        R_RET: begin
          state_r <= R_EPC;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= {CSR_MEPC, CSR_SET, 32'h0000_0000};
        end
        R_EPC: begin
          state_r          <= REDIR;
          redirect_pc_o    <= {csr_rdata_i[31:1], 1'b0};
          redirect_valid_o <= 1'b1;
          flush_o          <= 1'b1;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
        end
        REDIR: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= HALT;
          fatal_o <= 1'b1;
          busy_o  <= 1'b1;
          {csr_addr_o, csr_op_o, csr_wdata_o} <= IDLE_ACC;
        end
      endcase
    end
  end

endmodule
